// File: rtl/pla_vector_sweeper_pkg.sv
// Shared types and constants for the PLA vector sweeper.
// SWEEP_SIGNATURE_EN adds a 16-bit MISR signature of the sampled outputs.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } sweep_state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // One Galois MISR step: shift left, fold the feedback tap, inject y at bit 0.
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic y);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {15'b0, y};
  endfunction

endpackage

// File: rtl/pla_vector_sweeper_if.sv
// Bus between the sweeper and its user/netlist: control, vector, sample and results.
// SWEEP_SIGNATURE_EN adds the sig field.
interface pla_vector_sweeper_if #(
  parameter int N_IN  = 12,
  parameter int CNT_W = N_IN + 1
);
  logic             start;
  logic             hold;
  logic [N_IN-1:0]  x_out;
  logic             y_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] onset_count;
  logic [N_IN-1:0]  first_hit;
  logic [N_IN-1:0]  last_hit;
  logic             hit_vld;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]      sig;
`endif

  modport master (
    output start, hold, y_in,
    input  x_out, busy, done, onset_count, first_hit, last_hit, hit_vld
`ifdef SWEEP_SIGNATURE_EN
    , input sig
`endif
  );

  modport slave (
    input  start, hold, y_in,
    output x_out, busy, done, onset_count, first_hit, last_hit, hit_vld
`ifdef SWEEP_SIGNATURE_EN
    , output sig
`endif
  );

endinterface

// File: rtl/pla_vector_sweeper_acc.sv
// sweep_result_acc: one-stage sample pipeline feeding ON-set count/first/last accumulators.
// SWEEP_SIGNATURE_EN adds the MISR signature register.
module sweep_result_acc
  import pla_sweep_pkg::*;
#(
  parameter int N_IN  = 12,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cap_vld,
  input  logic [N_IN-1:0]  cap_idx,
  input  logic             cap_y,
  output logic [CNT_W-1:0] onset_count,
  output logic [N_IN-1:0]  first_hit,
  output logic [N_IN-1:0]  last_hit,
  output logic             hit_vld
`ifdef SWEEP_SIGNATURE_EN
  , output logic [15:0]    sig
`endif
);

  logic            p_vld;
  logic [N_IN-1:0] p_idx;
  logic            p_y;

  // NOTE: the pipeline registers are reset along with the results so an aborted
  // sweep cannot leave a stale valid sample to be counted after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld       <= 1'b0;
      p_idx       <= '0;
      p_y         <= 1'b0;
      onset_count <= '0;
      first_hit   <= '0;
      last_hit    <= '0;
      hit_vld     <= 1'b0;
    end else if (clr) begin
      p_vld       <= 1'b0;
      onset_count <= '0;
      first_hit   <= '0;
      last_hit    <= '0;
      hit_vld     <= 1'b0;
    end else begin
      p_vld <= cap_vld;
      p_idx <= cap_idx;
      p_y   <= cap_y;
      if (p_vld && p_y) begin
        onset_count <= onset_count + 1'b1;
        last_hit    <= p_idx;
        if (!hit_vld) begin
          first_hit <= p_idx;
          hit_vld   <= 1'b1;
        end
      end
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sig <= SIG_SEED;
    else if (clr)        sig <= SIG_SEED;
    else if (p_vld)      sig <= misr_next(sig, p_y);
  end
`endif

endmodule

// File: rtl/pla_vector_sweeper.sv
// Top: sweep FSM and vector counter driving a combinational PLA netlist.
// SWEEP_SIGNATURE_EN enables the sig output of the result accumulator.
module pla_vector_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int N_IN  = 12,
  parameter int CNT_W = N_IN + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pla_vector_sweeper_if.slave bus
);

  localparam logic [N_IN-1:0] X_LAST = '1;

  sweep_state_t    state;
  logic [N_IN-1:0] x_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;
  logic            cap_vld;

  // start is honoured only from IDLE/DONE; DRAIN ignores it, so a start on the
  // edge that enters DONE is dropped.
  assign accept  = bus.start && (state == IDLE || state == DONE);
  assign cap_vld = (state == SWEEP) && !bus.hold;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= SWEEP;
            x_q    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        SWEEP: begin
          if (!bus.hold) begin
            if (x_q == X_LAST) state <= DRAIN;  // last vector captured, no wrap
            else               x_q   <= x_q + 1'b1;
          end
        end
        DRAIN: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_out = x_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  sweep_result_acc #(
    .N_IN (N_IN),
    .CNT_W(CNT_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .cap_vld    (cap_vld),
    .cap_idx    (x_q),
    .cap_y      (bus.y_in),
    .onset_count(bus.onset_count),
    .first_hit  (bus.first_hit),
    .last_hit   (bus.last_hit),
    .hit_vld    (bus.hit_vld)
`ifdef SWEEP_SIGNATURE_EN
    , .sig      (bus.sig)
`endif
  );

endmodule

// File: tb/tb_pla_vector_sweeper.sv
// Self-checking bench for pla_vector_sweeper with behavioural PLA netlists on y_in.
// Signature checks are compiled in when SWEEP_SIGNATURE_EN is defined.
module tb_pla_vector_sweeper;

  localparam int N = 12;
  localparam int NL_MINTERM = 0;
  localparam int NL_ZERO    = 1;
  localparam int NL_ONE     = 2;
  localparam int NL_X0      = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pla_vector_sweeper_if #(.N_IN(N)) bus ();

  pla_vector_sweeper #(.N_IN(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         nl_mode = NL_ZERO;
  logic [N-1:0] nl_target = '0;

  always_comb begin
    case (nl_mode)
      NL_MINTERM: bus.y_in = (bus.x_out == nl_target);
      NL_ONE:     bus.y_in = 1'b1;
      NL_X0:      bus.y_in = bus.x_out[0];
      default:    bus.y_in = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a sweep (caller is mid-cycle). Edge #1 is the edge that samples start.
  // alt: hold high for even-numbered edges. late_start: edge number on which start
  // is high again (0 = never). Returns the edge number at which done was first seen.
  task automatic run_sweep(input bit alt, input int late_start, output int done_edge);
    done_edge  = -1;
    bus.start  = 1'b1;
    bus.hold   = 1'b0;
    for (int k = 1; k <= 9000; k++) begin
      @(posedge clk);
      #1;
      bus.start = (late_start != 0) && (k + 1 == late_start);
      bus.hold  = alt && ((k + 1) % 2 == 0);
      if (k == 1) begin
        check("start_x_out",  32'(bus.x_out), 32'h0);
        check("start_busy",   32'(bus.busy), 32'h1);
        check("start_done",   32'(bus.done), 32'h0);
        check("start_count",  32'(bus.onset_count), 32'h0);
        check("start_hitvld", 32'(bus.hit_vld), 32'h0);
      end
      if (bus.done) begin
        done_edge = k;
        break;
      end
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

`ifdef SWEEP_SIGNATURE_EN
  function automatic logic [15:0] misr_model(input logic [N-1:0] hit);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int v = 0; v < (1 << N); v++) begin
      fb = s[15];
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
      s[0] = s[0] ^ (v == int'(hit));
    end
    return s;
  endfunction
`endif

  typedef struct {
    int           mode;
    logic [N-1:0] target;
    bit           alt;
    int           exp_count;
    logic [N-1:0] exp_first;
    logic [N-1:0] exp_last;
    bit           exp_vld;
    int           exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int de;
    bit found;

    vecs[0] = '{NL_MINTERM, 12'hECE, 1'b0, 1,    12'hECE, 12'hECE, 1'b1, 4098};
    vecs[1] = '{NL_ZERO,    12'h000, 1'b0, 0,    12'h000, 12'h000, 1'b0, 4098};
    vecs[2] = '{NL_ONE,     12'h000, 1'b0, 4096, 12'h000, 12'hFFF, 1'b1, 4098};
    vecs[3] = '{NL_X0,      12'h000, 1'b1, 2048, 12'h001, 12'hFFF, 1'b1, 8194};
    vecs[4] = '{NL_MINTERM, 12'h000, 1'b0, 1,    12'h000, 12'h000, 1'b1, 4098};
    vecs[5] = '{NL_MINTERM, 12'hFFF, 1'b1, 1,    12'hFFF, 12'hFFF, 1'b1, 8194};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    #12;
    check("rst_x_out",  32'(bus.x_out), 32'h0);
    check("rst_busy",   32'(bus.busy), 32'h0);
    check("rst_done",   32'(bus.done), 32'h0);
    check("rst_count",  32'(bus.onset_count), 32'h0);
    check("rst_first",  32'(bus.first_hit), 32'h0);
    check("rst_last",   32'(bus.last_hit), 32'h0);
    check("rst_hitvld", 32'(bus.hit_vld), 32'h0);
`ifdef SWEEP_SIGNATURE_EN
    check("rst_sig",    32'(bus.sig), 32'hFFFF);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back sweeps: each start after the first is accepted from DONE.
    for (int i = 0; i < 6; i++) begin
      nl_mode   = vecs[i].mode;
      nl_target = vecs[i].target;
      run_sweep(vecs[i].alt, 0, de);
      check($sformatf("v%0d_done_edge", i), 32'(de), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_count", i),  32'(bus.onset_count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_first", i),  32'(bus.first_hit), 32'(vecs[i].exp_first));
      check($sformatf("v%0d_last", i),   32'(bus.last_hit), 32'(vecs[i].exp_last));
      check($sformatf("v%0d_hitvld", i), 32'(bus.hit_vld), 32'(vecs[i].exp_vld));
      check($sformatf("v%0d_busy", i),   32'(bus.busy), 32'h0);
      check($sformatf("v%0d_x_hold", i), 32'(bus.x_out), 32'hFFF);
    end

    // start on the edge that enters DONE is dropped.
    nl_mode   = NL_MINTERM;
    nl_target = 12'h123;
    run_sweep(1'b0, 4098, de);
    check("late_done_edge", 32'(de), 32'd4098);
    @(posedge clk);
    #1;
    check("late_done_kept", 32'(bus.done), 32'h1);
    check("late_busy",      32'(bus.busy), 32'h0);
    check("late_count",     32'(bus.onset_count), 32'h1);
    check("late_first",     32'(bus.first_hit), 32'h123);

    // Asynchronous reset mid-sweep at x_out = 0x400.
    nl_mode   = NL_ONE;
    bus.start = 1'b1;
    found     = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.x_out == 12'h400) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_400", 32'(found), 32'h1);
    check("abort_pre_count_nz", 32'(bus.onset_count != 0), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_x_out",  32'(bus.x_out), 32'h0);
    check("abort_busy",   32'(bus.busy), 32'h0);
    check("abort_done",   32'(bus.done), 32'h0);
    check("abort_count",  32'(bus.onset_count), 32'h0);
    check("abort_first",  32'(bus.first_hit), 32'h0);
    check("abort_last",   32'(bus.last_hit), 32'h0);
    check("abort_hitvld", 32'(bus.hit_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh sweep after abort, with a start pulse while busy that must be ignored.
    nl_mode   = NL_MINTERM;
    nl_target = 12'hECE;
    run_sweep(1'b0, 100, de);
    check("post_done_edge", 32'(de), 32'd4098);
    check("post_count",     32'(bus.onset_count), 32'h1);
    check("post_first",     32'(bus.first_hit), 32'hECE);
    check("post_last",      32'(bus.last_hit), 32'hECE);

`ifdef SWEEP_SIGNATURE_EN
    begin
      logic [15:0] sig_a, sig_b, sig_c;
      sig_a = bus.sig;
      check("sig_model_ece", 32'(sig_a), 32'(misr_model(12'hECE)));
      @(posedge clk);
      #1;
      check("sig_frozen", 32'(bus.sig), 32'(sig_a));
      run_sweep(1'b0, 0, de);
      sig_b = bus.sig;
      check("sig_repeat", 32'(sig_b), 32'(sig_a));
      nl_target = 12'hECF;
      run_sweep(1'b1, 0, de);
      sig_c = bus.sig;
      check("sig_model_ecf", 32'(sig_c), 32'(misr_model(12'hECF)));
      check("sig_differs", 32'(sig_c != sig_a), 32'h1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_vector_sweeper.md
Name: pla_vector_sweeper

Overview:
- Sequential stimulus/capture stage placed directly upstream of a combinational PLA benchmark netlist (inputs x0..x(N-1), single output y0).
- Sweeps every input vector 0..2^N_IN-1 into the netlist, samples the returned y0 through a 1-stage pipeline, and reports:
  - ON-set size,
  - first and last ON-set vector.
- Used on-chip/in-sim to cross-check optimised netlists against their originals without external vector files.

Parameters:
- N_IN, 12, number of netlist inputs; sweep length 2^N_IN.
- CNT_W, N_IN+1, width of onset counter (derived, holds 2^N_IN exactly).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a sweep when in IDLE or DONE.
- hold  input  1  stall; freezes vector advance and sampling while high.
- x_out  output  N_IN  registered vector to netlist, bit i drives x<i>.
- y_in  input  1  netlist y0, combinational from x_out.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high in DONE until next accepted start.
- onset_count  output  CNT_W  number of vectors with y_in=1.
- first_hit  output  N_IN  lowest vector with y_in=1.
- last_hit  output  N_IN  highest vector with y_in=1.
- hit_vld  output  1  at least one hit recorded this sweep.

Behaviour:
- Reset (async, rst_n=0): state IDLE. x_out, onset_count, first_hit, last_hit = 0. busy, done, hit_vld = 0. Pipeline valid = 0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start=1:
  - Clears onset_count, first_hit, last_hit, hit_vld.
  - x_out<=0, done<=0, go to SWEEP.
- SWEEP, hold=0, each cycle:
  - Pipeline stage captures {x_out, y_in} with valid=1.
  - x_out increments by 1.
  - When x_out == 2^N_IN-1 is captured, x_out holds and the state goes to DRAIN. No wrap to 0.
- SWEEP, hold=1: x_out unchanged, capture valid=0.
- Pipeline stage valid with y=1:
  - onset_count+1.
  - last_hit <= idx.
  - If hit_vld==0: first_hit <= idx and hit_vld <= 1.
- DRAIN: processes the last captured sample (hold ignored), then DONE with done=1.
- Latency: result final 2^N_IN + 2 cycles after start with hold=0. Each y_in is used once, sampled in the same cycle its vector is on x_out.
- start while busy: ignored. start on the same edge as the DONE transition: ignored. start in DONE: accepted.
- Reset mid-sweep: immediate abort to reset values. No partial results retained.
- onset_count saturation is impossible by width; a full ON-set reports 2^N_IN.

Optional Feature:
- Macro SWEEP_SIGNATURE_EN.
- Defined:
  - Extra output sig [15:0], a 16-bit MISR with polynomial x^16+x^12+x^5+1.
  - Each valid pipeline sample clocks in y, XORed into bit 0.
  - Cleared to 0xFFFF on reset and on accepted start; frozen in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package pla_sweep_pkg holds:
  - state enum sweep_state_t {IDLE, SWEEP, DRAIN, DONE},
  - MISR polynomial constant SIG_POLY = 16'h1021,
  - SIG_SEED = 16'hFFFF.
- One sub-module, sweep_result_acc: pipeline stage plus onset/first/last accumulators (and the MISR when enabled). The top keeps the FSM and vector counter.

Test Plan:
- Single-minterm AND netlist, N_IN=12, ON-set {0xECE}, hold=0, pulse start:
  - onset_count=1, first_hit=last_hit=0xECE, hit_vld=1.
  - done asserts at cycle 4098 after start.
- Constant-0 netlist: onset_count=0, hit_vld=0, first_hit=last_hit=0, done=1.
- Constant-1 netlist: onset_count=4096, first_hit=0x000, last_hit=0xFFF.
- y=x0 netlist with hold high on alternate cycles:
  - onset_count=2048, first_hit=0x001, last_hit=0xFFF.
  - done at cycle ~8194; no vector skipped or double-counted.
- rst_n low at x_out=0x400 mid-sweep: all outputs 0 asynchronously. Next start sweeps from 0 with fresh counts. start pulses while busy change nothing.
- With SWEEP_SIGNATURE_EN, two back-to-back sweeps of the same netlist: identical sig values. Sweep with ON-set {0xECE} vs ON-set {0xECF}: sig values differ.
